conv_sum_accumulator: RTL and testbench

Pipelined reduction stage directly downstream of the Hadamard product unit. Each accepted beat carries the SIZE element-wise kernel×patch products for one input channel. The block sums them with a registered adder tree and accumulates the per-channel sums across a channel group delimited by `in_last`. It then presents one convolution output word per group through a valid/ready handshake to the output writer.

---
 rtl/conv_sum_accumulator_if.sv | 27 ++
 rtl/conv_sum_accumulator.sv | 168 ++++++++++++++++
 tb/tb_conv_sum_accumulator.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_sum_accumulator_if.sv
// Stream bundle between the Hadamard product unit, the sum accumulator and the
// output writer. The block under design is the "slave" side: it consumes the
// product beats and produces result words. The "master" side is the environment.
interface conv_sum_accumulator_if #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 9,
    parameter int CNT_W = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic [SIZE-1:0][WIDTH-1:0]  products;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [WIDTH-1:0]            out_data;
    logic [CNT_W-1:0]            out_count;

    modport master (
        output in_valid, products, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, products, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/conv_sum_accumulator.sv
// Pipelined reduction of SIZE products per beat through a registered adder
// tree, followed by a per-group accumulator and a single-entry output register.
// One global enable stalls the whole pipeline while a result waits downstream.
module conv_sum_accumulator #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 9,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    conv_sum_accumulator_if.slave  bus
);

    localparam int LEVELS = $clog2(SIZE);

    // Number of elements alive at tree level k (level 0 is the raw beat).
    function automatic int level_w(input int k);
        int n;
        n = SIZE;
        for (int i = 0; i < k; i++) n = (n + 1) / 2;
        return n;
    endfunction

    typedef enum logic {
        IDLE,
        ACCUM
    } state_e;

    logic en;
    logic out_valid_q;

    // The pipeline moves only when the output register is free or being drained.
    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en;

    // ------------------------------------------------------------------
    // Adder tree
    // ------------------------------------------------------------------
    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int NW = level_w(k);

        logic [WIDTH-1:0] data_q [NW];
        logic             valid_q;
        logic             last_q;

        if (k == 0) begin : g_tap
            // Level 0 exposes the incoming beat under the same names as the
            // registered levels so every level reads its predecessor uniformly.
            always_comb begin
                for (int i = 0; i < NW; i++) data_q[i] = bus.products[i];
                valid_q = bus.in_valid;
                last_q  = bus.in_last;
            end
        end else begin : g_reg
            localparam int PW = level_w(k - 1);

            logic [WIDTH-1:0] data_d [NW];

            for (genvar i = 0; i < NW; i++) begin : g_node
                if (2 * i + 1 < PW) begin : g_add
                    assign data_d[i] = g_lvl[k-1].data_q[2*i] + g_lvl[k-1].data_q[2*i+1];
                end else begin : g_pass
                    assign data_d[i] = g_lvl[k-1].data_q[2*i];
                end
            end

            // Valid and last flags travel with the data and must come up clean.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end else if (en) begin
                    valid_q <= g_lvl[k-1].valid_q;
                    last_q  <= g_lvl[k-1].last_q;
                end
            end

            // Partial sums advance one level per enabled cycle.
            // NOTE: the data registers carry no reset; the valid bit alongside
            // them decides whether their contents are ever consumed.
            always_ff @(posedge clk) begin
                if (en) data_q <= data_d;
            end
        end
    end

    logic [WIDTH-1:0] tree_sum;
    logic             tree_valid;
    logic             tree_last;

    assign tree_sum   = g_lvl[LEVELS].data_q[0];
    assign tree_valid = g_lvl[LEVELS].valid_q;
    assign tree_last  = g_lvl[LEVELS].last_q;

    // ------------------------------------------------------------------
    // Group accumulator and output register
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [WIDTH-1:0] sum_next;
    logic [CNT_W-1:0] cnt_next;

    // Next-state logic: fold each tree result into the open group and publish
    // the total when the group's last channel arrives.
    always_comb begin
        // NOTE: every target gets a default first, so no path leaves a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        sum_next    = '0;
        cnt_next    = '0;

        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

        if (en && tree_valid) begin
            if (state_q == IDLE) begin
                sum_next = tree_sum;
                cnt_next = CNT_W'(1);
            end else begin
                sum_next = acc_q + tree_sum;
                cnt_next = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            end
            acc_d = sum_next;
            cnt_d = cnt_next;

            if (tree_last) begin
                // A fresh result wins over the pop of the previous one.
                out_valid_d = 1'b1;
                out_data_d  = sum_next;
                out_count_d = cnt_next;
                state_d     = IDLE;
            end else begin
                state_d = ACCUM;
            end
        end
    end

    // State, accumulator and output register update; reset drops any open group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_conv_sum_accumulator.sv
// Directed bench for conv_sum_accumulator: a group-level reference model checks
// every handshake, and literal expectations pin the model on each scenario.
module tb_conv_sum_accumulator;

    localparam int WIDTH = 32;
    localparam int SIZE  = 9;
    localparam int CNT_W = 16;
    localparam int LAT   = $clog2(SIZE) + 1;

    typedef logic [SIZE-1:0][WIDTH-1:0] beat_t;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] count;
    } result_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    conv_sum_accumulator_if #(.WIDTH(WIDTH), .SIZE(SIZE), .CNT_W(CNT_W)) bus ();

    conv_sum_accumulator #(.WIDTH(WIDTH), .SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model: sums whole groups as they are accepted and queues the
    // results they must produce, in order.
    // ------------------------------------------------------------------
    result_t          exp_q[$];
    logic [WIDTH-1:0] popped[$];
    logic [WIDTH-1:0] m_acc  = '0;
    int               m_cnt  = 0;
    bit               m_open = 1'b0;

    always @(negedge clk) begin
        logic [WIDTH-1:0] s;
        result_t          r;
        if (!rst_n) begin
            exp_q.delete();
            m_open = 1'b0;
        end else begin
            check("in_ready_vs_stall", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (bus.in_valid && bus.in_ready) begin
                s = '0;
                for (int i = 0; i < SIZE; i++) s = s + bus.products[i];
                m_acc  = m_open ? m_acc + s : s;
                m_cnt  = m_open ? ((m_cnt < 65535) ? m_cnt + 1 : 65535) : 1;
                m_open = !bus.in_last;
                if (bus.in_last) begin
                    r.data  = m_acc;
                    r.count = CNT_W'(m_cnt);
                    exp_q.push_back(r);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1'b1, 1'b0);
                end else begin
                    r = exp_q.pop_front();
                    check("model_data", bus.out_data, r.data);
                    check("model_count", bus.out_count, r.count);
                end
                popped.push_back(bus.out_data);
            end
        end
    end

    // Optional backpressure pattern on out_ready: 1,0,0,1,0,0,...
    bit bp_en    = 1'b0;
    int bp_phase = 0;

    always @(posedge clk) begin
        if (bp_en) begin
            #1;
            bus.out_ready = (bp_phase % 3 == 0);
            bp_phase++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (callers stand just after a rising edge)
    // ------------------------------------------------------------------
    function automatic beat_t splat(input logic [WIDTH-1:0] v);
        beat_t b;
        for (int i = 0; i < SIZE; i++) b[i] = v;
        return b;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input beat_t p, input bit last);
        bit ok;
        int guard;
        guard        = 0;
        bus.in_valid = 1'b1;
        bus.products = p;
        bus.in_last  = last;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!ok && guard < 100);
        if (!ok) check("accept_timeout", 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Counts falling edges until out_valid is seen (bounded).
    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 50);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        int    n;
        int    base;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.products  = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single beat of ones: 9, count 1, LAT edges including the acceptance edge.
        send_beat(splat(32'd1), 1'b1);
        wait_out(n);
        check("latency", n, LAT);
        check("ones_data", bus.out_data, 32'd9);
        check("ones_count", bus.out_count, 16'd1);
        sync();

        // Three-beat group {1..9}, {10..18}, {0..0}.
        for (int i = 0; i < SIZE; i++) b[i] = 32'(i + 1);
        send_beat(b, 1'b0);
        for (int i = 0; i < SIZE; i++) b[i] = 32'(i + 10);
        send_beat(b, 1'b0);
        send_beat(splat(32'd0), 1'b1);
        wait_out(n);
        check("multi_data", bus.out_data, 32'd171);
        check("multi_count", bus.out_count, 16'd3);
        sync();

        // Following group starts clean.
        send_beat(splat(32'd2), 1'b1);
        wait_out(n);
        check("no_leak_data", bus.out_data, 32'd18);
        check("no_leak_count", bus.out_count, 16'd1);
        sync();

        // Wrap-around of the data path.
        send_beat(splat(32'hFFFF_FFFF), 1'b1);
        wait_out(n);
        check("wrap_data", bus.out_data, 32'hFFFF_FFF7);
        check("wrap_count", bus.out_count, 16'd1);
        sync();

        // Idle cycles inside a group.
        base = popped.size();
        send_beat(splat(32'd1), 1'b0);
        repeat (3) sync();
        send_beat(splat(32'd1), 1'b1);
        wait_out(n);
        check("bubble_data", bus.out_data, 32'd18);
        check("bubble_count", bus.out_count, 16'd2);
        repeat (8) sync();
        check("bubble_single_result", popped.size() - base, 1);

        // Six back-to-back single-beat groups under backpressure.
        base     = popped.size();
        bp_phase = 0;
        bp_en    = 1'b1;
        for (int k = 1; k <= 6; k++) send_beat(splat(32'(k)), 1'b1);
        n = 0;
        while (popped.size() < base + 6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_result_count", popped.size() - base, 6);
        for (int k = 0; k < 6; k++) begin
            if (base + k < popped.size())
                check($sformatf("bp_result_%0d", k), popped[base+k], 32'(9 * (k + 1)));
        end
        @(posedge clk);
        bp_en = 1'b0;
        #2;
        bus.out_ready = 1'b1;
        sync();

        // Reset while a result is parked at the output.
        bus.out_ready = 1'b0;
        send_beat(splat(32'd5), 1'b1);
        wait_out(n);
        check("parked_valid", bus.out_valid, 1'b1);
        check("parked_data", bus.out_data, 32'd45);
        sync();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_count", bus.out_count, 16'd0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;
        sync();
        rst_n = 1'b1;

        // Reset in the middle of an open group discards it.
        send_beat(splat(32'd7), 1'b0);
        send_beat(splat(32'd7), 1'b0);
        rst_n = 1'b0;
        sync();
        rst_n = 1'b1;
        send_beat(splat(32'd3), 1'b1);
        wait_out(n);
        check("post_rst_data", bus.out_data, 32'd27);
        check("post_rst_count", bus.out_count, 16'd1);

        repeat (10) sync();
        check("model_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
